// File: rtl/unstripe_pkg.sv
// Shared constants for the 2-lane unstriping merger.
// Lane-pointer encoding, default sizes and drop-counter width.
package unstripe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int OVF_CNT_W  = 8;

  localparam logic [0:0] LANE0 = 1'b0;
  localparam logic [0:0] LANE1 = 1'b1;

endpackage

// File: rtl/unstriping_merge_lane_fifo.sv
// Per-lane synchronous FIFO absorbing skew between the two lanes.
// A push into a full buffer without a same-cycle pop is dropped and flagged.
module lane_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  // no bypass: a pop only ever sees what was stored before this edge
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case (1'b1)
      push_ok & ~pop_ok: count_d = count_q + CW'(1);
      pop_ok & ~push_ok: count_d = count_q - CW'(1);
      default:           count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/unstriping_merge.sv
// Merges two striped lanes back into one ordered stream (clk_2f domain).
// Define UNSTRIPE_OVF_CNT_EN to build the saturating dropped-word counter.
module unstriping_merge
  import unstripe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                 clk_2f,
  input  logic                 reset_L,
  input  logic [DATA_W-1:0]    data_in0,
  input  logic                 valid_in0,
  input  logic [DATA_W-1:0]    data_in1,
  input  logic                 valid_in1,
  output logic [DATA_W-1:0]    data_out,
  output logic                 valid_out,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  logic [DATA_W-1:0] rdata0, rdata1;
  logic              empty0, empty1;
  logic              full0, full1;
  logic              drop0, drop1;
  logic              pop0, pop1, pop;

  logic [0:0]        lane_q, lane_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              overflow_q, overflow_d;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk     (clk_2f),
    .reset_L (reset_L),
    .push    (valid_in0),
    .pop     (pop0),
    .wdata   (data_in0),
    .rdata   (rdata0),
    .empty   (empty0),
    .full    (full0),
    .drop    (drop0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk     (clk_2f),
    .reset_L (reset_L),
    .push    (valid_in1),
    .pop     (pop1),
    .wdata   (data_in1),
    .rdata   (rdata1),
    .empty   (empty1),
    .full    (full1),
    .drop    (drop1)
  );

  // stall on an empty expected lane rather than skip it
  assign pop0 = (lane_q == LANE0) & ~empty0;
  assign pop1 = (lane_q == LANE1) & ~empty1;
  assign pop  = pop0 | pop1;

  always_comb begin
    lane_d      = lane_q;
    data_out_d  = data_out_q;
    valid_out_d = pop;
    overflow_d  = overflow_q | drop0 | drop1;
    unique case (1'b1)
      pop0: begin
        data_out_d = rdata0;
        lane_d     = LANE1;
      end
      pop1: begin
        data_out_d = rdata1;
        lane_d     = LANE0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      lane_q      <= LANE0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;

`ifdef UNSTRIPE_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [OVF_CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, ovf_cnt_q}
            + {{OVF_CNT_W{1'b0}}, drop0}
            + {{OVF_CNT_W{1'b0}}, drop1};
    ovf_cnt_d = cnt_sum[OVF_CNT_W] ? '1 : cnt_sum[OVF_CNT_W-1:0];
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`else
  logic unused_full;
  assign unused_full = full0 | full1;
  assign ovf_count   = '0;
`endif

endmodule
